// File: rtl/mouse_master_sm_if.sv
// Host-side PS/2 mouse signals around the protocol controller: the transmitter
// and receiver handshakes plus the packet presented to the host.
interface mouse_master_sm_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic       BYTE_READY;
  logic [7:0] BYTE_RECEIVED;
  logic [1:0] BYTE_ERROR_CODE;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic [3:0] MASTER_STATE;

  // Controller side
  modport master (
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    output MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT, MASTER_STATE,
    input  BYTE_SENT, BYTE_READY, BYTE_RECEIVED, BYTE_ERROR_CODE
  );

  // Transmitter, receiver and host side
  modport slave (
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    input  MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT, MASTER_STATE,
    output BYTE_SENT, BYTE_READY, BYTE_RECEIVED, BYTE_ERROR_CODE
  );
endinterface

// File: rtl/mouse_master_sm.sv
// PS/2 mouse protocol controller: runs the reset/enable bring-up handshake,
// then assembles 3-byte stream packets and presents them with an interrupt.
module mouse_master_sm #(
  parameter int unsigned T_INIT = 32'd5000000,
  parameter int unsigned T_RESP = 32'd100000000
) (
  input logic                CLK,
  input logic                RESET,
  mouse_master_sm_if.master  bus
);

  localparam int unsigned TIMER_W = 32;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [BYTE_W-1:0] CMD_RESET    = 8'hFF;
  localparam logic [BYTE_W-1:0] CMD_ENABLE   = 8'hF4;
  localparam logic [BYTE_W-1:0] RSP_ACK      = 8'hFA;
  localparam logic [BYTE_W-1:0] RSP_SELFTEST = 8'hAA;
  localparam logic [BYTE_W-1:0] RSP_ID       = 8'h00;

  localparam logic [TIMER_W-1:0] INIT_LAST = TIMER_W'(T_INIT - 32'd1);
  localparam logic [TIMER_W-1:0] RESP_LAST = TIMER_W'(T_RESP - 32'd1);

  typedef enum logic [STATE_W-1:0] {
    INIT_WAIT     = 4'd0,
    SEND_RST      = 4'd1,
    WAIT_RST_SENT = 4'd2,
    WAIT_ACK1     = 4'd3,
    WAIT_SELFTEST = 4'd4,
    WAIT_ID       = 4'd5,
    SEND_EN       = 4'd6,
    WAIT_EN_SENT  = 4'd7,
    WAIT_ACK2     = 4'd8,
    RX_B1         = 4'd9,
    RX_B2         = 4'd10,
    RX_B3         = 4'd11,
    PKT_DONE      = 4'd12
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [TIMER_W-1:0]   timer;

  logic                 rx_clean;
  logic                 wd_expired;
  logic                 send_c;
  logic [BYTE_W-1:0]    cmd_c;
  logic                 read_en_c;
  logic                 ld_status_c;
  logic                 ld_dx_c;
  logic                 pkt_load_c;

  logic                 send_q;
  logic [BYTE_W-1:0]    byte_to_send_q;
  logic                 read_en_q;
  logic [STATE_W-1:0]   master_state_q;
  logic [BYTE_W-1:0]    shadow_status_q;
  logic [BYTE_W-1:0]    shadow_dx_q;
  logic [BYTE_W-1:0]    mouse_status_q;
  logic [BYTE_W-1:0]    mouse_dx_q;
  logic [BYTE_W-1:0]    mouse_dy_q;
  logic                 interrupt_q;

  // Next-state and next-output decode
  always_comb begin
    state_nx    = state;
    rx_clean    = bus.BYTE_READY && (bus.BYTE_ERROR_CODE == 2'b00);
    wd_expired  = (timer == RESP_LAST);
    send_c      = 1'b0;
    cmd_c       = byte_to_send_q;
    read_en_c   = 1'b0;
    ld_status_c = 1'b0;
    ld_dx_c     = 1'b0;
    pkt_load_c  = 1'b0;

    case (state)
      INIT_WAIT: begin
        if (timer == INIT_LAST) state_nx = SEND_RST;
      end
      SEND_RST: begin
        send_c   = 1'b1;
        cmd_c    = CMD_RESET;
        state_nx = WAIT_RST_SENT;
      end
      WAIT_RST_SENT: begin
        if (bus.BYTE_SENT)     state_nx = WAIT_ACK1;
        else if (wd_expired)   state_nx = SEND_RST;
      end
      WAIT_ACK1: begin
        if (bus.BYTE_READY)
          state_nx = (rx_clean && bus.BYTE_RECEIVED == RSP_ACK) ? WAIT_SELFTEST : SEND_RST;
        else if (wd_expired)
          state_nx = SEND_RST;
      end
      WAIT_SELFTEST: begin
        if (bus.BYTE_READY)
          state_nx = (rx_clean && bus.BYTE_RECEIVED == RSP_SELFTEST) ? WAIT_ID : SEND_RST;
        else if (wd_expired)
          state_nx = SEND_RST;
      end
      WAIT_ID: begin
        if (bus.BYTE_READY)
          state_nx = (rx_clean && bus.BYTE_RECEIVED == RSP_ID) ? SEND_EN : SEND_RST;
        else if (wd_expired)
          state_nx = SEND_RST;
      end
      SEND_EN: begin
        send_c   = 1'b1;
        cmd_c    = CMD_ENABLE;
        state_nx = WAIT_EN_SENT;
      end
      WAIT_EN_SENT: begin
        if (bus.BYTE_SENT)     state_nx = WAIT_ACK2;
        else if (wd_expired)   state_nx = SEND_RST;
      end
      WAIT_ACK2: begin
        if (bus.BYTE_READY)
          state_nx = (rx_clean && bus.BYTE_RECEIVED == RSP_ACK) ? RX_B1 : SEND_RST;
        else if (wd_expired)
          state_nx = SEND_RST;
      end
      RX_B1: begin
        // Only a clean byte with the sync bit set can start a packet
        if (rx_clean && bus.BYTE_RECEIVED[3]) begin
          ld_status_c = 1'b1;
          state_nx    = RX_B2;
        end
      end
      RX_B2: begin
        if (rx_clean) begin
          ld_dx_c  = 1'b1;
          state_nx = RX_B3;
        end else if (bus.BYTE_READY) begin
          state_nx = RX_B1;
        end
      end
      RX_B3: begin
        // dY goes straight to the output so all three bytes land on one edge
        if (rx_clean) begin
          pkt_load_c = 1'b1;
          state_nx   = PKT_DONE;
        end else if (bus.BYTE_READY) begin
          state_nx = RX_B1;
        end
      end
      PKT_DONE: begin
        state_nx = RX_B1;
      end
      default: begin
        state_nx = INIT_WAIT;
      end
    endcase

    case (state_nx)
      WAIT_ACK1, WAIT_SELFTEST, WAIT_ID, WAIT_ACK2,
      RX_B1, RX_B2, RX_B3, PKT_DONE: read_en_c = 1'b1;
      default:                       read_en_c = 1'b0;
    endcase
  end

  // State register and shared timer, cleared on every state change
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= INIT_WAIT;
      timer <= '0;
    end else begin
      state <= state_nx;
      timer <= (state_nx != state) ? '0 : timer + TIMER_W'(1);
    end
  end

  // Registered outputs and packet shadow registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      send_q          <= 1'b0;
      byte_to_send_q  <= '0;
      read_en_q       <= 1'b0;
      master_state_q  <= '0;
      shadow_status_q <= '0;
      shadow_dx_q     <= '0;
      mouse_status_q  <= '0;
      mouse_dx_q      <= '0;
      mouse_dy_q      <= '0;
      interrupt_q     <= 1'b0;
    end else begin
      send_q         <= send_c;
      byte_to_send_q <= cmd_c;
      read_en_q      <= read_en_c;
      master_state_q <= STATE_W'(state_nx);
      interrupt_q    <= pkt_load_c;
      if (ld_status_c) shadow_status_q <= bus.BYTE_RECEIVED;
      if (ld_dx_c)     shadow_dx_q     <= bus.BYTE_RECEIVED;
      if (pkt_load_c) begin
        mouse_status_q <= shadow_status_q;
        mouse_dx_q     <= shadow_dx_q;
        mouse_dy_q     <= bus.BYTE_RECEIVED;
      end
    end
  end

  assign bus.SEND_BYTE      = send_q;
  assign bus.BYTE_TO_SEND   = byte_to_send_q;
  assign bus.READ_ENABLE    = read_en_q;
  assign bus.MASTER_STATE   = master_state_q;
  assign bus.MOUSE_STATUS   = mouse_status_q;
  assign bus.MOUSE_DX       = mouse_dx_q;
  assign bus.MOUSE_DY       = mouse_dy_q;
  assign bus.SEND_INTERRUPT = interrupt_q;

endmodule
